// File: rtl/fft_iter_pkg.sv
// Shared definitions for the iterative radix-2 FFT address path.
// Holds the layer/butterfly sizing used by the control unit and the span/shift
// helpers used by both the DIF and DIT address mappings.
package fft_iter_pkg;

  localparam int FFT_LAYERS      = 5;
  localparam int FFT_BUTTERFLYES = 16;
  localparam int FFT_LAYWL       = 3;
  localparam int FFT_BUTTWL      = 4;

  // RAM address width: one bit more than the butterfly counter
  function automatic int addr_w(int butt_wl);
    return butt_wl + 1;
  endfunction

  // log2 of the butterfly leg span h in DIF: h = 2^(LAYERS-1-s)
  function automatic int unsigned dif_span_sh(int unsigned layers, int unsigned s);
    return layers - 1 - s;
  endfunction

  // log2 of the butterfly leg span h in DIT: h = 2^s
  function automatic int unsigned dit_span_sh(int unsigned layers, int unsigned s);
    return (layers > 0) ? s : 0;
  endfunction

endpackage

// File: rtl/fft_iter_addr_gen_if.sv
// Strobe/address bundle between the FFT control unit (master) and the
// address generator (slave).
interface fft_iter_addr_gen_if
  import fft_iter_pkg::*;
#(
  parameter int ButtWL = FFT_BUTTWL,
  parameter int LayWL  = FFT_LAYWL
) ();
  localparam int AW = addr_w(ButtWL);

  logic              EN;
  logic              ADDR_RST;
  logic              ADDR_EN;
  logic              LAY_EN;
  logic              BUT_STROB;
  logic [AW-1:0]     RD_ADDR_A;
  logic [AW-1:0]     RD_ADDR_B;
  logic [AW-1:0]     WR_ADDR_A;
  logic [AW-1:0]     WR_ADDR_B;
  logic [ButtWL-1:0] TW_ADDR;
  logic [LayWL-1:0]  LAY_IDX;

  modport master (
    output EN, ADDR_RST, ADDR_EN, LAY_EN, BUT_STROB,
    input  RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B, TW_ADDR, LAY_IDX
  );

  modport slave (
    input  EN, ADDR_RST, ADDR_EN, LAY_EN, BUT_STROB,
    output RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B, TW_ADDR, LAY_IDX
  );
endinterface

// File: rtl/fft_iter_pair_map.sv
// Combinational butterfly -> RAM pair / twiddle index mapping.
// Default build is DIF; define FFT_ADDR_DIT_EN for decimation-in-time.
// A = 2hg + j is built as (g << (log2h+1)) | j, B = A | h, since j < h.
module fft_iter_pair_map
  import fft_iter_pkg::*;
#(
  parameter int LAYERS = FFT_LAYERS,
  parameter int ButtWL = FFT_BUTTWL,
  parameter int LayWL  = FFT_LAYWL,
  localparam int AW    = addr_w(ButtWL)
) (
  input  logic [ButtWL-1:0] b_i,
  input  logic [LayWL-1:0]  s_i,
  output logic [AW-1:0]     a_o,
  output logic [AW-1:0]     b_o,
  output logic [ButtWL-1:0] tw_o
);

  int unsigned   sh_h;
  int unsigned   sh_tw;
  logic [AW-1:0] bx, h, j, g, a;

  // Split b into group g and offset j by the layer's span, then rebuild the pair
  always_comb begin
`ifdef FFT_ADDR_DIT_EN
    sh_h  = dit_span_sh(LAYERS, 32'(s_i));
    sh_tw = dif_span_sh(LAYERS, 32'(s_i));
`else
    sh_h  = dif_span_sh(LAYERS, 32'(s_i));
    sh_tw = dit_span_sh(LAYERS, 32'(s_i));
`endif
    bx   = {1'b0, b_i};
    h    = AW'(1) << sh_h;
    j    = bx & (h - AW'(1));
    g    = bx >> sh_h;
    a    = (g << (sh_h + 1)) | j;
    a_o  = a;
    b_o  = a | h;
    tw_o = ButtWL'(j << sh_tw);
  end

endmodule

// File: rtl/fft_iter_addr_gen.sv
// Address generator for the iterative radix-2 FFT: butterfly/layer counters
// and the latched write-back pair. Mapping lives in fft_iter_pair_map.
// Build option: FFT_ADDR_DIT_EN selects the decimation-in-time mapping.
module fft_iter_addr_gen
  import fft_iter_pkg::*;
#(
  parameter int LAYERS      = FFT_LAYERS,
  parameter int BUTTERFLYES = FFT_BUTTERFLYES,
  parameter int LayWL       = FFT_LAYWL,
  parameter int ButtWL      = FFT_BUTTWL
) (
  input  logic                CLK,
  input  logic                RST,
  fft_iter_addr_gen_if.slave  bus
);
  localparam int AW = addr_w(ButtWL);
  localparam logic [ButtWL-1:0] B_LAST = ButtWL'(BUTTERFLYES - 1);
  localparam logic [LayWL-1:0]  S_LAST = LayWL'(LAYERS - 1);

  logic [ButtWL-1:0] b_q, b_d;
  logic [LayWL-1:0]  s_q, s_d;
  logic [AW-1:0]     wa_q, wa_d, wb_q, wb_d;
  logic [AW-1:0]     rd_a, rd_b;
  logic [ButtWL-1:0] tw;

  fft_iter_pair_map #(.LAYERS(LAYERS), .ButtWL(ButtWL), .LayWL(LayWL)) u_map (
    .b_i  (b_q),
    .s_i  (s_q),
    .a_o  (rd_a),
    .b_o  (rd_b),
    .tw_o (tw)
  );

  // Next state: strobes act only under EN; write pair latches pre-advance addresses
  always_comb begin
    b_d  = b_q;
    s_d  = s_q;
    wa_d = wa_q;
    wb_d = wb_q;
    if (bus.EN) begin
      if (bus.BUT_STROB) begin
        wa_d = rd_a;
        wb_d = rd_b;
      end
      if (bus.ADDR_EN)
        b_d = (b_q == B_LAST) ? '0 : b_q + ButtWL'(1);
      if (bus.LAY_EN && (s_q != S_LAST))
        s_d = s_q + LayWL'(1);
    end
  end

  // State registers; RST and ADDR_RST both clear regardless of EN
  always_ff @(posedge CLK) begin
    if (RST || bus.ADDR_RST) begin
      b_q  <= '0;
      s_q  <= '0;
      wa_q <= '0;
      wb_q <= '0;
    end else begin
      b_q  <= b_d;
      s_q  <= s_d;
      wa_q <= wa_d;
      wb_q <= wb_d;
    end
  end

  assign bus.RD_ADDR_A = rd_a;
  assign bus.RD_ADDR_B = rd_b;
  assign bus.WR_ADDR_A = wa_q;
  assign bus.WR_ADDR_B = wb_q;
  assign bus.TW_ADDR   = tw;
  assign bus.LAY_IDX   = s_q;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Scoreboard bench for fft_iter_addr_gen (LAYERS=5). Driver updates an
// arithmetic reference model and queues the expected outputs; a negedge
// monitor pops and compares. Directed test-plan points are checked inline.
module tb_fft_iter_addr_gen;
  localparam int L = 5;
  localparam int NB = 16;

  typedef struct {
    int ra, rb, wa, wb, tw, lay;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  // model state
  int mb = 0, ms = 0, mwa = 0, mwb = 0;

  fft_iter_addr_gen_if #(.ButtWL(4), .LayWL(3)) bus ();

  fft_iter_addr_gen #(.LAYERS(L), .BUTTERFLYES(NB), .LayWL(3), .ButtWL(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference mapping straight from the butterfly definitions
  function automatic void pair(int b, int s, output int a, output int bb, output int tw);
    int h;
`ifdef FFT_ADDR_DIT_EN
    h  = 2 ** s;
    tw = (b % h) * (2 ** (L - 1 - s));
`else
    h  = 2 ** (L - 1 - s);
    tw = (b % h) * (2 ** s);
`endif
    a  = 2 * h * (b / h) + (b % h);
    bb = a + h;
  endfunction

  task automatic step(bit en, bit arst, bit aen, bit len, bit bst, bit rr);
    int   a, bb, tw;
    exp_t e;
    bus.EN = en; bus.ADDR_RST = arst; bus.ADDR_EN = aen;
    bus.LAY_EN = len; bus.BUT_STROB = bst; rst = rr;
    if (rr || arst) begin
      mb = 0; ms = 0; mwa = 0; mwb = 0;
    end else if (en) begin
      if (bst) begin
        pair(mb, ms, a, bb, tw);
        mwa = a; mwb = bb;
      end
      if (aen) mb = (mb + 1) % NB;
      if (len && ms < L - 1) ms++;
    end
    pair(mb, ms, a, bb, tw);
    e = '{a, bb, mwa, mwb, tw, ms};
    @(posedge clk);
    #1;
    sb.push_back(e);
  endtask

  task automatic idle();   step(1, 0, 0, 0, 0, 0); endtask
  task automatic do_rst(); step(1, 0, 0, 0, 0, 1); endtask
  task automatic adv(int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 0, 0, 0);
  endtask
  task automatic lay(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 1, 0, 0);
  endtask

  task automatic rd_chk(string nm, int a, int b, int tw);
    chk({nm, "_rda"}, int'(bus.RD_ADDR_A), a);
    chk({nm, "_rdb"}, int'(bus.RD_ADDR_B), b);
    chk({nm, "_tw"},  int'(bus.TW_ADDR), tw);
  endtask

  // Monitor: outputs are valid every cycle, compare against the queued model
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_rda", int'(bus.RD_ADDR_A), e.ra);
      chk("sb_rdb", int'(bus.RD_ADDR_B), e.rb);
      chk("sb_wra", int'(bus.WR_ADDR_A), e.wa);
      chk("sb_wrb", int'(bus.WR_ADDR_B), e.wb);
      chk("sb_tw",  int'(bus.TW_ADDR),   e.tw);
      chk("sb_lay", int'(bus.LAY_IDX),   e.lay);
    end
  end

  initial begin
    bus.EN = 1'b1; bus.ADDR_RST = 1'b0; bus.ADDR_EN = 1'b0;
    bus.LAY_EN = 1'b0; bus.BUT_STROB = 1'b0;

    // reset state
    do_rst();
`ifdef FFT_ADDR_DIT_EN
    rd_chk("reset", 0, 1, 0);
`else
    rd_chk("reset", 0, 16, 0);
`endif
    chk("reset_wra", int'(bus.WR_ADDR_A), 0);
    chk("reset_wrb", int'(bus.WR_ADDR_B), 0);
    chk("reset_lay", int'(bus.LAY_IDX), 0);

    // s=0 mappings
    adv(3);
`ifndef FFT_ADDR_DIT_EN
    rd_chk("dif_s0_b3", 3, 19, 3);
`endif
    adv(2);
`ifdef FFT_ADDR_DIT_EN
    rd_chk("dit_s0_b5", 10, 11, 0);
`endif

    // s=2, b=5 (same values in both mappings)
    do_rst(); lay(2); adv(5);
    rd_chk("s2_b5", 9, 13, 4);

    // s=4, b=3
    do_rst(); lay(4); adv(3);
`ifdef FFT_ADDR_DIT_EN
    rd_chk("dit_s4_b3", 3, 19, 3);
`else
    rd_chk("dif_s4_b3", 6, 7, 0);
`endif

    // BUT_STROB with ADDR_EN at b=7, s=0
    do_rst(); adv(7);
    step(1, 0, 1, 0, 1, 0);
`ifdef FFT_ADDR_DIT_EN
    chk("strob_wra", int'(bus.WR_ADDR_A), 14);
    chk("strob_wrb", int'(bus.WR_ADDR_B), 15);
    chk("strob_rda", int'(bus.RD_ADDR_A), 16);
`else
    chk("strob_wra", int'(bus.WR_ADDR_A), 7);
    chk("strob_wrb", int'(bus.WR_ADDR_B), 23);
    chk("strob_rda", int'(bus.RD_ADDR_A), 8);
`endif
    adv(2);
    chk("strob_hold_wra", int'(bus.WR_ADDR_A), mwa);

    // butterfly wrap with LAY_EN on the last pulse, then layer saturation
    do_rst(); adv(15);
    step(1, 0, 1, 1, 0, 0);
    chk("wrap_rda", int'(bus.RD_ADDR_A), 0);
    chk("wrap_lay", int'(bus.LAY_IDX), 1);
    do_rst(); lay(5);
    chk("sat_lay", int'(bus.LAY_IDX), 4);

    // ADDR_RST together with ADDR_EN mid-layer
    do_rst(); lay(3); adv(9); step(1, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("arst_wra", int'(bus.WR_ADDR_A), 0);
    chk("arst_wrb", int'(bus.WR_ADDR_B), 0);
    chk("arst_lay", int'(bus.LAY_IDX), 0);
    chk("arst_rda", int'(bus.RD_ADDR_A), 0);

    // EN low holds everything; RST still clears
    lay(3); adv(9); step(1, 0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    chk("enlow_lay", int'(bus.LAY_IDX), 3);
    step(0, 0, 1, 1, 0, 1);
    chk("rst_en0_wra", int'(bus.WR_ADDR_A), 0);
    chk("rst_en0_lay", int'(bus.LAY_IDX), 0);
    lay(2); step(0, 1, 0, 0, 0, 0);
    chk("arst_en0_lay", int'(bus.LAY_IDX), 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);

    idle(); idle();
    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #6;
    chk("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
